// File: rtl/pong_pkg.sv
// Shared types and screen geometry for the pong paddle logic.
package pong_pkg;

   typedef enum logic [1:0] {
      P_IDLE,
      P_RAMP,
      P_CRUISE
   } paddle_state_t;

   typedef enum logic [1:0] {
      DIR_NONE,
      DIR_UP,
      DIR_DOWN
   } paddle_dir_t;

   localparam int Y_MIN    = 20;
   localparam int Y_MAX    = 461;
   localparam int Y_CENTER = 240;

endpackage

// File: rtl/paddle_array_if.sv
// Control inputs and paddle geometry outputs shared between the game logic and the paddle array.
interface paddle_array_if #(
   parameter int NUM_PADDLES = 2
);

   logic                      round_reset;
   logic                      freeze;
   logic [NUM_PADDLES-1:0]    up_key;
   logic [NUM_PADDLES-1:0]    down_key;
   logic [NUM_PADDLES-1:0]    cpu_mode;
   logic [9:0]                ball_y;
   logic [10*NUM_PADDLES-1:0] paddle_y;
   logic [10*NUM_PADDLES-1:0] paddle_x;
   logic [9:0]                paddle_len;
   logic [9:0]                paddle_w;
   logic [NUM_PADDLES-1:0]    moving;

   modport master (
      output round_reset, freeze, up_key, down_key, cpu_mode, ball_y,
      input  paddle_y, paddle_x, paddle_len, paddle_w, moving
   );

   modport slave (
      input  round_reset, freeze, up_key, down_key, cpu_mode, ball_y,
      output paddle_y, paddle_x, paddle_len, paddle_w, moving
   );

endinterface

// File: rtl/paddle_axis.sv
// One paddle: direction request, speed-ramp FSM and clamped vertical position.
module paddle_axis
   import pong_pkg::*;
#(
   parameter int Y_MIN        = pong_pkg::Y_MIN,
   parameter int Y_MAX        = pong_pkg::Y_MAX,
   parameter int Y_CENTER     = pong_pkg::Y_CENTER,
   parameter int HALF_LEN     = 35,
   parameter int STEP_MIN     = 2,
   parameter int STEP_INC     = 2,
   parameter int STEP_MAX     = 8,
   parameter int RAMP_FRAMES  = 4,
   parameter int CPU_DEADBAND = 4
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       round_reset,
   input  logic       freeze,
   input  logic       up_key,
   input  logic       down_key,
   input  logic       cpu_mode,
   input  logic [9:0] ball_y,
   output logic [9:0] paddle_y,
   output logic       moving
);

   localparam logic signed [10:0] Y_LO     = 11'(Y_MIN + HALF_LEN);
   localparam logic signed [10:0] Y_HI     = 11'(Y_MAX - HALF_LEN);
   localparam logic signed [10:0] DEADBAND = 11'(CPU_DEADBAND);
   localparam logic [9:0]         Y_CTR    = 10'(Y_CENTER);
   localparam logic [9:0]         SPD_MIN  = 10'(STEP_MIN);
   localparam logic [9:0]         SPD_INC  = 10'(STEP_INC);
   localparam logic [9:0]         SPD_MAX  = 10'(STEP_MAX);
   localparam logic [9:0]         RAMP_CNT = 10'(RAMP_FRAMES);

   paddle_state_t     state_q, state_d;
   paddle_dir_t       dir_q, dir_d, req;
   logic [9:0]        speed_q, speed_d;
   logic [9:0]        count_q, count_d;
   logic [9:0]        y_q, y_d;
   logic              moving_q, moving_d;
   logic signed [10:0] y_s, ball_s, y_next;

   assign y_s    = signed'({1'b0, y_q});
   assign ball_s = signed'({1'b0, ball_y});

   // CPU tracking ignores the keys; conflicting manual keys cancel out.
   always_comb begin
      req = DIR_NONE;
      if (cpu_mode) begin
         if (ball_s > y_s + DEADBAND) begin
            req = DIR_DOWN;
         end else if (ball_s < y_s - DEADBAND) begin
            req = DIR_UP;
         end
      end else if (down_key && !up_key) begin
         req = DIR_DOWN;
      end else if (up_key && !down_key) begin
         req = DIR_UP;
      end
   end

   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      speed_d  = speed_q;
      count_d  = count_q;
      y_d      = y_q;
      moving_d = 1'b0;
      y_next   = y_s;
      if (!freeze) begin
         if (req == DIR_NONE) begin
            state_d = P_IDLE;
            dir_d   = DIR_NONE;
            speed_d = '0;
            count_d = '0;
         end else begin
            if (state_q == P_IDLE || req != dir_q) begin
               speed_d = SPD_MIN;
               count_d = 10'd1;
            end else if (state_q == P_RAMP) begin
               if (count_q == RAMP_CNT) begin
                  speed_d = (speed_q + SPD_INC > SPD_MAX) ? SPD_MAX : speed_q + SPD_INC;
                  count_d = 10'd1;
               end else begin
                  count_d = count_q + 10'd1;
               end
            end
            dir_d   = req;
            state_d = (speed_d >= SPD_MAX) ? P_CRUISE : P_RAMP;
            // Move by the freshly selected speed so a new request moves on the same edge.
            y_next  = (req == DIR_DOWN) ? y_s + signed'({1'b0, speed_d})
                                        : y_s - signed'({1'b0, speed_d});
            if (y_next < Y_LO) begin
               y_next = Y_LO;
            end else if (y_next > Y_HI) begin
               y_next = Y_HI;
            end
            y_d      = y_next[9:0];
            moving_d = (y_d != y_q);
         end
      end
   end

   always_ff @(posedge frame_clk) begin
      if (Reset || round_reset) begin
         state_q  <= P_IDLE;
         dir_q    <= DIR_NONE;
         speed_q  <= '0;
         count_q  <= '0;
         y_q      <= Y_CTR;
         moving_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         speed_q  <= speed_d;
         count_q  <= count_d;
         y_q      <= y_d;
         moving_q <= moving_d;
      end
   end

   assign paddle_y = y_q;
   assign moving   = moving_q;

endmodule

// File: rtl/paddle_array.sv
// Array of independent paddles sharing one frame clock, reset, pause and ball position.
module paddle_array
   import pong_pkg::*;
#(
   parameter int                      NUM_PADDLES  = 2,
   parameter int                      Y_MIN        = pong_pkg::Y_MIN,
   parameter int                      Y_MAX        = pong_pkg::Y_MAX,
   parameter int                      HALF_LEN     = 35,
   parameter int                      PAD_W        = 2,
   parameter int                      Y_CENTER     = pong_pkg::Y_CENTER,
   parameter logic [10*NUM_PADDLES-1:0] X_POS      = {10'd550, 10'd60},
   parameter int                      STEP_MIN     = 2,
   parameter int                      STEP_INC     = 2,
   parameter int                      STEP_MAX     = 8,
   parameter int                      RAMP_FRAMES  = 4,
   parameter int                      CPU_DEADBAND = 4
) (
   input logic           frame_clk,
   input logic           Reset,
   paddle_array_if.slave bus
);

   if (STEP_MIN == 0 || STEP_MAX < STEP_MIN || 2 * HALF_LEN > Y_MAX - Y_MIN) begin : g_bad_cfg
      $error("paddle_array: invalid speed ramp or paddle length configuration");
   end

   logic [10*NUM_PADDLES-1:0] y_all;
   logic [NUM_PADDLES-1:0]    moving_all;

   for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_pad
      paddle_axis #(
         .Y_MIN        (Y_MIN),
         .Y_MAX        (Y_MAX),
         .Y_CENTER     (Y_CENTER),
         .HALF_LEN     (HALF_LEN),
         .STEP_MIN     (STEP_MIN),
         .STEP_INC     (STEP_INC),
         .STEP_MAX     (STEP_MAX),
         .RAMP_FRAMES  (RAMP_FRAMES),
         .CPU_DEADBAND (CPU_DEADBAND)
      ) u_axis (
         .frame_clk   (frame_clk),
         .Reset       (Reset),
         .round_reset (bus.round_reset),
         .freeze      (bus.freeze),
         .up_key      (bus.up_key[i]),
         .down_key    (bus.down_key[i]),
         .cpu_mode    (bus.cpu_mode[i]),
         .ball_y      (bus.ball_y),
         .paddle_y    (y_all[10*i +: 10]),
         .moving      (moving_all[i])
      );
   end

   assign bus.paddle_y   = y_all;
   assign bus.moving     = moving_all;
   assign bus.paddle_x   = X_POS;
   assign bus.paddle_len = 10'(HALF_LEN);
   assign bus.paddle_w   = 10'(PAD_W);

endmodule

// File: doc/paddle_array.md
PADDLE_ARRAY -- requirements
Module: paddle_array

Interface
REQ-001 Parameter NUM_PADDLES, default 2: number of independent paddles.
REQ-002 Parameter Y_MIN / Y_MAX, default 20 / 461: playfield vertical limits, inclusive.
REQ-003 Parameter HALF_LEN / PAD_W, default 35 / 2: paddle half-length and width.
REQ-004 Parameter Y_CENTER, default 240: recentre position.
REQ-005 Parameter X_POS, default {10'd550, 10'd60}: packed per-paddle X positions, 10 bits each, paddle 0 in the LSBs.
REQ-006 Parameter STEP_MIN / STEP_INC / STEP_MAX, default 2 / 2 / 8: per-frame speed ramp in pixels.
REQ-007 Parameter RAMP_FRAMES, default 4: frames spent at each speed before the next increment.
REQ-008 Parameter CPU_DEADBAND, default 4: CPU-mode tracking tolerance in pixels.
REQ-009 Port frame_clk, input, 1: the only clock; every action is taken on its rising edge.
REQ-010 Port Reset, input, 1: synchronous, active-high reset.
REQ-011 Port round_reset, input, 1: synchronous recentre of all paddles between points.
REQ-012 Port freeze, input, 1: pause; holds all state.
REQ-013 Port up_key / down_key, input, NUM_PADDLES: manual move requests, one bit per paddle.
REQ-014 Port cpu_mode, input, NUM_PADDLES: 1 = paddle tracks ball_y and ignores its keys.
REQ-015 Port ball_y, input, 10: ball centre Y.
REQ-016 Port paddle_y / paddle_x, output, 10*NUM_PADDLES: paddle centres, packed.
REQ-017 Port paddle_len / paddle_w, output, 10: HALF_LEN and PAD_W, constant.
REQ-018 Port moving, output, NUM_PADDLES: 1 when that paddle's Y changed on the last edge.

Function
REQ-019 Each paddle SHALL form a direction request every frame:
- Manual, both keys or neither asserted: none.
- Manual, down_key only: +1; up_key only: -1.
- CPU: +1 if ball_y > y+CPU_DEADBAND; -1 if ball_y < y-CPU_DEADBAND; else none.
REQ-020 Each paddle SHALL run an FSM with states P_IDLE, P_RAMP and P_CRUISE, a speed register and a frame counter.
REQ-021 From P_IDLE, a request SHALL select P_RAMP with speed=STEP_MIN and count=1, and move in the same edge (zero-frame latency).
REQ-022 In P_RAMP with an unchanged direction and count=RAMP_FRAMES, the FSM SHALL apply speed=min(speed+STEP_INC, STEP_MAX) and reset count to 1; otherwise it SHALL increment count.
REQ-023 When speed reaches STEP_MAX, the FSM SHALL enter P_CRUISE and hold that speed.
REQ-024 A reversed direction in P_RAMP or P_CRUISE SHALL re-enter P_RAMP at STEP_MIN, count=1, moving in the new direction on that edge.
REQ-025 No request SHALL move the FSM to P_IDLE with speed 0 and leave Y unchanged.
REQ-026 Next Y SHALL be y plus or minus the new speed, computed in 11-bit signed arithmetic and clamped to [Y_MIN+HALF_LEN, Y_MAX-HALF_LEN]; it never underflows or overshoots.
REQ-027 At a clamp limit the FSM state and speed SHALL continue; Y holds and moving=0.
REQ-028 A cpu_mode change SHALL take effect on the next edge with no reset of the FSM.
REQ-029 When freeze=1, Y, FSM, speed, count and moving SHALL hold, and moving SHALL be forced to 0.

Reset
REQ-030 Reset SHALL set every paddle_y to Y_CENTER, FSM to P_IDLE, speed and count to 0, and moving to 0.
REQ-031 round_reset SHALL have the same effect as Reset.
REQ-032 Priority SHALL be Reset > round_reset > freeze > normal operation; a reset in mid-ramp SHALL discard the ramp.
REQ-033 paddle_x, paddle_len and paddle_w SHALL be constant from parameters at all times.

Structure
REQ-034 Package pong_pkg SHALL hold the paddle_state_t enum (P_IDLE, P_RAMP, P_CRUISE) and the shared screen constants (Y_MIN, Y_MAX, Y_CENTER).
REQ-035 A sub-module paddle_axis SHALL implement one paddle; paddle_array SHALL instantiate it NUM_PADDLES times in a generate loop.
REQ-036 An elaboration check SHALL reject configurations with STEP_MIN=0, STEP_MAX<STEP_MIN, or 2*HALF_LEN > Y_MAX-Y_MIN.

Verification
REQ-037 Ramp: after Reset, hold down_key[0] for 13 frames -> paddle_y[0] = 242, 244, 246, 248, 252, 256, 260, 264, 270, 276, 282, 288, 296, with P_CRUISE entered at frame 13.
REQ-038 Clamp: hold up_key[0] for 40 frames from 240 -> paddle_y[0] stops at exactly 55 with moving=0 thereafter; holding down_key stops it at exactly 426.
REQ-039 Reversal: after 6 down frames (y=256), switch to up -> next y=254 and the state is P_RAMP; both keys asserted -> y holds and the state is P_IDLE.
REQ-040 CPU: cpu_mode[1]=1, ball_y=300, y=240 -> y=242 on the next edge; ball_y=242 with y=240 -> no motion.
REQ-041 Freeze and reset: freeze mid-cruise for 5 frames -> y and state unchanged, then motion resumes at the same speed; round_reset during cruise -> y=240 and P_IDLE on the next edge.
REQ-042 Independence: NUM_PADDLES=4 with distinct key patterns -> each paddle_y matches its own single-paddle reference model.
